// File: rtl/nlfsr_period_engine.sv
// nlfsr_period_engine
// Runs a parametrised NLFSR from a one-hot MSB seed until the seed comes back
// and reports the measured cycle length. A full period (2^SIZE-1) is reported
// as found. A short cycle, watchdog expiry or out-of-range tap index is
// reported as failure. Tap indices and the feedback form are captured on start
// so the candidate generator can change its inputs while a test runs.
module nlfsr_period_engine #(
    parameter int SIZE        = 11,
    parameter int NUM_OF_TAPS = 6,
    parameter int CNT_W       = 36
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode,
    input  logic [NUM_OF_TAPS*8-1:0] co_buf,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic                     failure,
    output logic                     taps_err,
    output logic [CNT_W-1:0]         cycle_len
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PERIOD   = (ONE << SIZE) - ONE;
    localparam logic [CNT_W-1:0] WATCHDOG = PERIOD + CNT_W'(4);
    localparam logic [SIZE-1:0]  INIT_VAL = {1'b1, {(SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_d;
    logic [SIZE-1:0]          lfsr;
    logic [SIZE-1:0]          lfsr_d;
    logic [SIZE-1:0]          lfsr_next;
    logic [CNT_W-1:0]         step;
    logic [CNT_W-1:0]         step_d;
    logic [CNT_W-1:0]         step_inc;
    logic [NUM_OF_TAPS*8-1:0] taps_q;
    logic [NUM_OF_TAPS*8-1:0] taps_d;
    logic                     mode_q;
    logic                     mode_d;
    logic                     found_d;
    logic                     failure_d;
    logic                     taps_err_d;
    logic [CNT_W-1:0]         cycle_len_d;
    logic [NUM_OF_TAPS-1:0]   tap_bit;
    logic                     feedback;
    logic                     bad_index;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign step_inc  = step + ONE;
    assign lfsr_next = {feedback, lfsr[SIZE-1:1]};

    // Tap decode: index 0 means a constant-zero tap, 1..SIZE-1 select a state bit
    always_comb begin
        tap_bit = '0;
        for (int j = 0; j < NUM_OF_TAPS; j++) begin
            for (int k = 1; k < SIZE; k++) begin
                if (taps_q[j*8 +: 8] == 8'(k)) begin
                    tap_bit[j] = lfsr[k];
                end
            end
        end
    end

    // Feedback: the AND term covers the first two taps (mode 0) or three (mode 1)
    always_comb begin
        feedback = lfsr[0];
        if (mode_q) begin
            feedback = feedback ^ (tap_bit[0] & tap_bit[1] & tap_bit[2]);
            for (int j = 3; j < NUM_OF_TAPS; j++) begin
                feedback = feedback ^ tap_bit[j];
            end
        end else begin
            feedback = feedback ^ (tap_bit[0] & tap_bit[1]);
            for (int j = 2; j < NUM_OF_TAPS; j++) begin
                feedback = feedback ^ tap_bit[j];
            end
        end
    end

    // Index range check on the incoming candidate, used at the moment of capture
    always_comb begin
        bad_index = 1'b0;
        for (int j = 0; j < NUM_OF_TAPS; j++) begin
            if ({24'd0, co_buf[j*8 +: 8]} >= 32'(SIZE)) begin
                bad_index = 1'b1;
            end
        end
    end

    // Next-state and next-result logic; abort overrides everything including start
    always_comb begin
        state_d     = state;
        lfsr_d      = lfsr;
        step_d      = step;
        taps_d      = taps_q;
        mode_d      = mode_q;
        found_d     = found;
        failure_d   = failure;
        taps_err_d  = taps_err;
        cycle_len_d = cycle_len;
        if (abort) begin
            state_d     = IDLE;
            found_d     = 1'b0;
            failure_d   = 1'b0;
            taps_err_d  = 1'b0;
            cycle_len_d = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        taps_d      = co_buf;
                        mode_d      = mode;
                        lfsr_d      = INIT_VAL;
                        step_d      = '0;
                        found_d     = 1'b0;
                        failure_d   = 1'b0;
                        taps_err_d  = 1'b0;
                        cycle_len_d = '0;
                        if (bad_index) begin
                            state_d    = DONE;
                            taps_err_d = 1'b1;
                            failure_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    lfsr_d = lfsr_next;
                    step_d = step_inc;
                    if (lfsr_next == INIT_VAL) begin
                        cycle_len_d = step_inc;
                        state_d     = DONE;
                        if (step_inc == PERIOD) begin
                            found_d = 1'b1;
                        end else begin
                            failure_d = 1'b1;
                        end
                    end else if (step_inc == WATCHDOG) begin
                        failure_d   = 1'b1;
                        cycle_len_d = step_inc;
                        state_d     = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, shift register, counter and result registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            lfsr      <= INIT_VAL;
            step      <= '0;
            taps_q    <= '0;
            mode_q    <= 1'b0;
            found     <= 1'b0;
            failure   <= 1'b0;
            taps_err  <= 1'b0;
            cycle_len <= '0;
        end else begin
            state     <= state_d;
            lfsr      <= lfsr_d;
            step      <= step_d;
            taps_q    <= taps_d;
            mode_q    <= mode_d;
            found     <= found_d;
            failure   <= failure_d;
            taps_err  <= taps_err_d;
            cycle_len <= cycle_len_d;
        end
    end

endmodule

// File: tb/tb_nlfsr_period_engine.sv
// Testbench for nlfsr_period_engine: one SIZE=4 and one SIZE=11 instance,
// each checked every cycle against a software NLFSR model of the test.
module tb_nlfsr_period_engine;

    logic        clk = 1'b0;
    logic        res      [2];
    logic        start    [2];
    logic        abort    [2];
    logic        mode     [2];
    logic [47:0] co       [2];
    logic        busy     [2];
    logic        done     [2];
    logic        found    [2];
    logic        failure  [2];
    logic        taps_err [2];
    logic [35:0] clen     [2];

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    // Expected test record per instance (rec_act=0 means idle, all outputs zero)
    bit     rec_act [2];
    longint rec_t0  [2];
    longint rec_len [2];
    bit     rec_f   [2];
    bit     rec_fl  [2];
    bit     rec_te  [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nlfsr_period_engine #(.SIZE(4), .NUM_OF_TAPS(6), .CNT_W(36)) u_dut4 (
        .clk(clk), .res(res[0]), .start(start[0]), .abort(abort[0]),
        .mode(mode[0]), .co_buf(co[0]), .busy(busy[0]), .done(done[0]),
        .found(found[0]), .failure(failure[0]), .taps_err(taps_err[0]),
        .cycle_len(clen[0])
    );

    nlfsr_period_engine #(.SIZE(11), .NUM_OF_TAPS(6), .CNT_W(36)) u_dut11 (
        .clk(clk), .res(res[1]), .start(start[1]), .abort(abort[1]),
        .mode(mode[1]), .co_buf(co[1]), .busy(busy[1]), .done(done[1]),
        .found(found[1]), .failure(failure[1]), .taps_err(taps_err[1]),
        .cycle_len(clen[1])
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Software NLFSR: step from the seed until it recurs and classify the result
    function automatic void model_run(input int size, input bit md, input logic [47:0] cb,
                                      output bit f_o, output bit fl_o, output bit te_o,
                                      output longint len_o);
        longint    period;
        bit [63:0] st;
        bit [63:0] init;
        int        idx [6];
        bit        t   [6];
        bit        fb;
        period = (longint'(1) << size) - 1;
        te_o = 1'b0;
        for (int j = 0; j < 6; j++) begin
            idx[j] = int'(cb[j*8 +: 8]);
            if (idx[j] >= size) te_o = 1'b1;
        end
        f_o = 1'b0;
        fl_o = 1'b1;
        len_o = 0;
        if (te_o) return;
        init = 64'd1 << (size - 1);
        st = init;
        for (longint k = 1; k <= period + 4; k++) begin
            for (int j = 0; j < 6; j++) t[j] = (idx[j] == 0) ? 1'b0 : st[idx[j]];
            fb = st[0] ^ (md ? (t[0] & t[1] & t[2]) : (t[0] & t[1]));
            for (int j = (md ? 3 : 2); j < 6; j++) fb = fb ^ t[j];
            st = st >> 1;
            st[size-1] = fb;
            if (st == init) begin
                len_o = k;
                f_o = (k == period);
                fl_o = !f_o;
                return;
            end
        end
        len_o = period + 4;
    endfunction

    // Per-cycle comparison of both instances against their expected records
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit     eb, ed, ef, efl, ete;
            longint el, n;
            string  sx;
            sx = (d == 0) ? "s4" : "s11";
            eb = 0; ed = 0; ef = 0; efl = 0; ete = 0; el = 0;
            if (rec_act[d]) begin
                n = cyc - rec_t0[d];
                if (rec_te[d]) begin
                    ed = 1; efl = 1; ete = 1;
                end else if (n < rec_len[d]) begin
                    eb = 1;
                end else begin
                    ed = 1; ef = rec_f[d]; efl = rec_fl[d]; el = rec_len[d];
                end
            end
            checkOutput({sx, "_busy"}, longint'(busy[d]), longint'(eb));
            checkOutput({sx, "_done"}, longint'(done[d]), longint'(ed));
            checkOutput({sx, "_found"}, longint'(found[d]), longint'(ef));
            checkOutput({sx, "_failure"}, longint'(failure[d]), longint'(efl));
            checkOutput({sx, "_taps_err"}, longint'(taps_err[d]), longint'(ete));
            checkOutput({sx, "_cycle_len"}, longint'(clen[d]), el);
        end
    end

    // Pulse start for one edge, then scramble the inputs to prove they were captured
    task automatic applyStimulus(input int d, input logic [47:0] cb, input bit md);
        bit     f, fl, te;
        longint len;
        model_run((d == 0) ? 4 : 11, md, cb, f, fl, te, len);
        @(posedge clk); #1;
        co[d] = cb; mode[d] = md; start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0; co[d] = ~cb; mode[d] = ~md;
        rec_act[d] = 1'b1; rec_t0[d] = cyc; rec_len[d] = len;
        rec_f[d] = f; rec_fl[d] = fl; rec_te[d] = te;
    endtask

    task automatic waitDone(input int d);
        longint k = 0;
        while (done[d] !== 1'b1 && k < rec_len[d] + 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (done[d] !== 1'b1) checkOutput("done_timeout", longint'(done[d]), 1);
    endtask

    task automatic checkResult(input int d, input string tag, input bit f, input bit fl,
                               input bit te, input longint len);
        checkOutput({tag, "_found"}, longint'(found[d]), longint'(f));
        checkOutput({tag, "_failure"}, longint'(failure[d]), longint'(fl));
        checkOutput({tag, "_taps_err"}, longint'(taps_err[d]), longint'(te));
        checkOutput({tag, "_len"}, longint'(clen[d]), len);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        bit          mf, mfl, mte;
        longint      mlen;
        logic [47:0] cb;
        for (int d = 0; d < 2; d++) begin
            res[d] = 1'b1; start[d] = 1'b0; abort[d] = 1'b0; mode[d] = 1'b0;
            co[d] = '0; rec_act[d] = 1'b0;
        end

        // Pin the model with hand-derived results
        model_run(4, 0, 48'h0000_0001_0000, mf, mfl, mte, mlen);
        checkOutput("model_s4_prim_len", mlen, 15);
        checkOutput("model_s4_prim_found", longint'(mf), 1);
        model_run(4, 0, 48'h0, mf, mfl, mte, mlen);
        checkOutput("model_s4_rot_len", mlen, 4);
        model_run(4, 0, 48'h0004_0000_0000, mf, mfl, mte, mlen);
        checkOutput("model_s4_terr", longint'(mte), 1);
        model_run(11, 0, 48'h0000_0002_0000, mf, mfl, mte, mlen);
        checkOutput("model_s11_prim_len", mlen, 2047);
        model_run(11, 0, 48'h0, mf, mfl, mte, mlen);
        checkOutput("model_s11_rot_len", mlen, 11);

        repeat (3) @(posedge clk);
        #1;
        res[0] = 1'b0; res[1] = 1'b0;
        @(posedge clk); #1;
        checkResult(0, "rst_s4", 0, 0, 0, 0);
        checkOutput("rst_s4_done", longint'(done[0]), 0);

        // SIZE=4 primitive, rotation and tap error
        applyStimulus(0, 48'h0000_0001_0000, 0);
        waitDone(0);
        checkResult(0, "s4_prim", 1, 0, 0, 15);
        checkOutput("s4_prim_latency", cyc - rec_t0[0] + 1, 16);
        applyStimulus(0, 48'h0, 0);
        waitDone(0);
        checkResult(0, "s4_rot", 0, 1, 0, 4);
        applyStimulus(0, 48'h0004_0000_0000, 0);
        waitDone(0);
        checkResult(0, "s4_terr", 0, 1, 1, 0);
        checkOutput("s4_terr_latency", cyc - rec_t0[0] + 1, 1);
        checkOutput("s4_terr_busy", longint'(busy[0]), 0);

        // SIZE=11 full period then a short cycle back-to-back from DONE
        applyStimulus(1, 48'h0000_0002_0000, 0);
        waitDone(1);
        checkResult(1, "s11_prim", 1, 0, 0, 2047);
        applyStimulus(1, 48'h0, 0);
        waitDone(1);
        checkResult(1, "s11_rot", 0, 1, 0, 11);

        // Random mode=1 candidates against the model
        for (int r = 0; r < 100; r++) begin
            for (int j = 0; j < 6; j++)
                cb[j*8 +: 8] = ($urandom_range(0, 20) == 0) ? 8'd4 : 8'($urandom_range(0, 3));
            applyStimulus(0, cb, 1);
            waitDone(0);
        end
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < 6; j++) cb[j*8 +: 8] = 8'($urandom_range(0, 10));
            applyStimulus(1, cb, 1);
            waitDone(1);
        end

        // Asynchronous reset at step 7, then a fresh test
        applyStimulus(1, 48'h0000_0002_0000, 0);
        repeat (7) @(posedge clk);
        #2;
        res[1] = 1'b1;
        rec_act[1] = 1'b0;
        #1;
        checkResult(1, "async_rst", 0, 0, 0, 0);
        checkOutput("async_rst_busy", longint'(busy[1]), 0);
        checkOutput("async_rst_done", longint'(done[1]), 0);
        @(posedge clk); #1;
        res[1] = 1'b0;
        applyStimulus(1, 48'h0, 0);
        waitDone(1);
        checkResult(1, "post_rst", 0, 1, 0, 11);

        // Abort at step 3 with start also high: back to idle, nothing launched
        applyStimulus(1, 48'h0000_0002_0000, 0);
        repeat (2) @(posedge clk);
        #1;
        abort[1] = 1'b1; start[1] = 1'b1; co[1] = 48'h0;
        @(posedge clk); #1;
        abort[1] = 1'b0; start[1] = 1'b0;
        rec_act[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkResult(1, "abort", 0, 0, 0, 0);
        checkOutput("abort_busy", longint'(busy[1]), 0);

        // Start while busy is ignored
        applyStimulus(1, 48'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        co[1] = 48'h0000_0002_0000; start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        waitDone(1);
        checkResult(1, "start_busy", 0, 1, 0, 11);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
